scratch_memory_arbiter: RTL and testbench



---
 rtl/scratch_memory_arbiter.sv | 133 +++++++++++++
 tb/tb_scratch_memory_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/scratch_memory_arbiter.sv
// Round-robin arbiter sharing one scratch memory between two requesters, with
// lock support for read-modify-write, a registered memory command and tagged read return.
module scratch_memory_arbiter #(
    parameter int READ_LATENCY = 0,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic         req0_we,
    input  logic         req0_lock,
    input  logic [15:0]  req0_address,
    input  logic [127:0] req0_wdata,
    input  logic         req1_valid,
    input  logic         req1_we,
    input  logic         req1_lock,
    input  logic [15:0]  req1_address,
    input  logic [127:0] req1_wdata,
    output logic         req0_grant,
    output logic         req1_grant,
    output logic         req0_rdata_valid,
    output logic         req1_rdata_valid,
    output logic [127:0] rdata,
    output logic         mem_we,
    output logic [15:0]  mem_write_address,
    output logic [127:0] mem_wdata,
    output logic [15:0]  mem_read_address,
    input  logic [127:0] mem_rdata,
    output logic         lock_timeout_error
);
    localparam int CNT_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int STAGES = READ_LATENCY;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(LOCK_TIMEOUT);

    logic             last, locked, owner;
    logic [CNT_W-1:0] idle_cnt, idle_next;
    logic [STAGES:0]  vld_pipe, id_pipe;
    logic [1:0]       valid_v, grant_v;
    logic             any_gnt, gnt_id, gnt_we, gnt_lock, owner_gnt;
    logic [15:0]      gnt_addr;
    logic [127:0]     gnt_wdata;

    // Lock state is registered, so the other requester can only win the cycle after release.
    always_comb begin
        valid_v = {req1_valid, req0_valid};
        grant_v = '0;
        if (!reset) begin
            if (locked)
                grant_v[owner] = valid_v[owner];
            else if (&valid_v)
                grant_v[~last] = 1'b1;
            else
                grant_v = valid_v;
        end
    end

    assign req0_grant = grant_v[0];
    assign req1_grant = grant_v[1];
    assign any_gnt    = |grant_v;
    assign gnt_id     = grant_v[1];
    assign gnt_we     = gnt_id ? req1_we      : req0_we;
    assign gnt_lock   = gnt_id ? req1_lock    : req0_lock;
    assign gnt_addr   = gnt_id ? req1_address : req0_address;
    assign gnt_wdata  = gnt_id ? req1_wdata   : req0_wdata;
    assign owner_gnt  = locked && grant_v[owner];
    assign idle_next  = idle_cnt + CNT_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last               <= 1'b1;
            locked             <= 1'b0;
            owner              <= 1'b0;
            idle_cnt           <= '0;
            lock_timeout_error <= 1'b0;
        end else begin
            if (any_gnt) begin
                last   <= gnt_id;
                locked <= gnt_lock;
                if (gnt_lock)
                    owner <= gnt_id;
            end
            if (!locked || owner_gnt) begin
                idle_cnt <= '0;
            end else begin
                // No grant is possible on this path, so the drop cannot collide with a new lock.
                idle_cnt <= idle_next;
                if (idle_next == TIMEOUT_VAL) begin
                    locked             <= 1'b0;
                    lock_timeout_error <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_we            <= 1'b0;
            mem_write_address <= '0;
            mem_wdata         <= '0;
            mem_read_address  <= '0;
        end else begin
            mem_we <= any_gnt && gnt_we;
            if (any_gnt && gnt_we) begin
                mem_write_address <= gnt_addr;
                mem_wdata         <= gnt_wdata;
            end
            if (any_gnt && !gnt_we)
                mem_read_address <= gnt_addr;
        end
    end

    // Read tags travel alongside the memory latency; stage STAGES lines up with mem_rdata.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe         <= '0;
            id_pipe          <= '0;
            rdata            <= '0;
            req0_rdata_valid <= 1'b0;
            req1_rdata_valid <= 1'b0;
        end else begin
            vld_pipe[0] <= any_gnt && !gnt_we;
            id_pipe[0]  <= gnt_id;
            for (int i = 1; i <= STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
            req0_rdata_valid <= vld_pipe[STAGES] && !id_pipe[STAGES];
            req1_rdata_valid <= vld_pipe[STAGES] &&  id_pipe[STAGES];
            if (vld_pipe[STAGES])
                rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_scratch_memory_arbiter.sv
// Directed bench for scratch_memory_arbiter with a combinational-read scratch memory model.
module tb_scratch_memory_arbiter;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 0, req0_we = 0, req0_lock = 0;
    logic         req1_valid = 0, req1_we = 0, req1_lock = 0;
    logic [15:0]  req0_address = '0, req1_address = '0;
    logic [127:0] req0_wdata = '0, req1_wdata = '0;
    logic         req0_grant, req1_grant, req0_rdata_valid, req1_rdata_valid;
    logic [127:0] rdata, mem_wdata, mem_rdata;
    logic         mem_we, lock_timeout_error;
    logic [15:0]  mem_write_address, mem_read_address;

    logic         pre_we = 1'b0;
    logic [15:0]  pre_addr = '0;
    logic [127:0] pre_data = '0;
    logic [127:0] mem [0:65535];

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] PAT_A5  = {16{8'hA5}};
    localparam logic [127:0] BIN_OLD = 128'h41;

    scratch_memory_arbiter #(.READ_LATENCY(0), .LOCK_TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
        .req0_address(req0_address), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
        .req1_address(req1_address), .req1_wdata(req1_wdata),
        .req0_grant(req0_grant), .req1_grant(req1_grant),
        .req0_rdata_valid(req0_rdata_valid), .req1_rdata_valid(req1_rdata_valid),
        .rdata(rdata), .mem_we(mem_we), .mem_write_address(mem_write_address),
        .mem_wdata(mem_wdata), .mem_read_address(mem_read_address),
        .mem_rdata(mem_rdata), .lock_timeout_error(lock_timeout_error)
    );

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_read_address];
    always @(posedge clock) begin
        if (mem_we) mem[mem_write_address] <= mem_wdata;
        if (pre_we) mem[pre_addr] <= pre_data;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_we = 0; req0_lock = 0;
        req1_valid = 0; req1_we = 0; req1_lock = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state, grants forced low while reset is high
        #1;
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("rst_grant0", req0_grant, 0);
        chk("rst_grant1", req1_grant, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_raddr", mem_read_address, 0);
        chk("rst_waddr", mem_write_address, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rv0", req0_rdata_valid, 0);
        chk("rst_rv1", req1_rdata_valid, 0);
        chk("rst_err", lock_timeout_error, 0);
        idle_inputs();
        tick();
        reset = 1'b0;

        pre_we = 1; pre_addr = 16'h0005; pre_data = PAT_A5;
        tick();
        pre_addr = 16'h0010; pre_data = BIN_OLD;
        tick();
        pre_we = 0;

        // Single read
        req0_valid = 1; req0_address = 16'h0005;
        #1;
        chk("sr_grant0", req0_grant, 1);
        chk("sr_grant1", req1_grant, 0);
        tick();
        req0_valid = 0;
        chk("sr_raddr", mem_read_address, 16'h0005);
        chk("sr_mem_we", mem_we, 0);
        tick();
        chk("sr_rv0", req0_rdata_valid, 1);
        chk("sr_rv1", req1_rdata_valid, 0);
        chk("sr_rdata", rdata, PAT_A5);

        // Conflict after reset: 0 wins first, then alternation
        do_reset();
        req0_address = 16'h0005; req1_address = 16'h0010;
        for (int k = 0; k < 8; k++) begin
            req0_valid = (k < 6); req1_valid = (k < 6);
            #1;
            if (k < 6) begin
                chk($sformatf("cf_g0_%0d", k), req0_grant, (k % 2 == 0));
                chk($sformatf("cf_g1_%0d", k), req1_grant, (k % 2 == 1));
            end
            if (k >= 2) begin
                chk($sformatf("cf_rv0_%0d", k), req0_rdata_valid, (k % 2 == 0));
                chk($sformatf("cf_rv1_%0d", k), req1_rdata_valid, (k % 2 == 1));
                chk($sformatf("cf_rd_%0d", k), rdata, (k % 2 == 0) ? PAT_A5 : BIN_OLD);
            end
            tick();
        end
        idle_inputs();

        // Locked read-modify-write of bin 0x0010
        req0_valid = 1; req0_we = 0; req0_lock = 1; req0_address = 16'h0010;
        req1_valid = 1; req1_we = 0; req1_address = 16'h0010;
        #1;
        chk("rmw_rd_g0", req0_grant, 1);
        chk("rmw_rd_g1", req1_grant, 0);
        tick();
        req0_valid = 0;
        #1;
        chk("rmw_wait_g1", req1_grant, 0);
        tick();
        chk("rmw_rv0", req0_rdata_valid, 1);
        chk("rmw_rdata", rdata, BIN_OLD);
        req0_valid = 1; req0_we = 1; req0_lock = 0; req0_wdata = rdata + 128'd1;
        #1;
        chk("rmw_wr_g0", req0_grant, 1);
        chk("rmw_wr_g1", req1_grant, 0);
        tick();
        req0_valid = 0; req0_we = 0;
        #1;
        chk("rmw_rel_g1", req1_grant, 1);
        chk("rmw_mem_we", mem_we, 1);
        chk("rmw_waddr", mem_write_address, 16'h0010);
        chk("rmw_wdata", mem_wdata, BIN_OLD + 128'd1);
        tick();
        req1_valid = 0;
        tick();
        chk("rmw_rv1", req1_rdata_valid, 1);
        chk("rmw_bin", rdata, BIN_OLD + 128'd1);

        // Lock timeout: owner goes silent for 16 cycles
        req0_valid = 1; req0_lock = 1; req0_address = 16'h0005;
        req1_valid = 1; req1_address = 16'h0005;
        #1;
        chk("to_g0", req0_grant, 1);
        tick();
        req0_valid = 0; req0_lock = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("to_hold_g1_%0d", i), req1_grant, 0);
            chk($sformatf("to_hold_err_%0d", i), lock_timeout_error, 0);
            tick();
        end
        #1;
        chk("to_err", lock_timeout_error, 1);
        chk("to_g1", req1_grant, 1);
        tick();
        req1_valid = 0;
        chk("to_err_sticky", lock_timeout_error, 1);
        tick();
        tick();

        // Reset in the cycle after a granted read flushes it
        req1_valid = 1; req1_we = 0; req1_address = 16'h0005;
        #1;
        chk("mr_g1", req1_grant, 1);
        tick();
        req1_valid = 0;
        reset = 1'b1;
        #1;
        chk("mr_raddr", mem_read_address, 0);
        chk("mr_err", lock_timeout_error, 0);
        chk("mr_rdata", rdata, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mr_rv1_%0d", i), req1_rdata_valid, 0);
            tick();
        end

        // Write then read on the next cycle sees the new data
        req0_valid = 1; req0_we = 1; req0_address = 16'h1234; req0_wdata = 128'h7;
        #1;
        chk("wr_g0", req0_grant, 1);
        tick();
        req0_valid = 0; req0_we = 0;
        req1_valid = 1; req1_we = 0; req1_address = 16'h1234;
        #1;
        chk("wr_g1", req1_grant, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_waddr", mem_write_address, 16'h1234);
        chk("wr_wdata", mem_wdata, 128'h7);
        tick();
        req1_valid = 0;
        chk("wr_mem_we_low", mem_we, 0);
        chk("wr_raddr", mem_read_address, 16'h1234);
        tick();
        chk("wr_rv1", req1_rdata_valid, 1);
        chk("wr_rv0", req0_rdata_valid, 0);
        chk("wr_rdata", rdata, 128'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
